mul_app_arbiter: RTL and testbench
==================================

MUL_APP_ARBITER -- requirements
Module: mul_app_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8); ID_W = clog2(NREQ).
REQ-002 Parameter XW, default 16, SHALL set the operand width; product width = 2*XW.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  SHALL mean requester i presents an operand pair.
REQ-006 req_ready  output  NREQ  SHALL mean requester i's pair is accepted this cycle; at most one bit high.
REQ-007 req_a  input  NREQ*XW  SHALL carry operand A of requester i in bits [i*XW +: XW].
REQ-008 req_b  input  NREQ*XW  SHALL carry operand B of requester i in bits [i*XW +: XW].
REQ-009 out_valid  output  1  SHALL mean out_data/out_id hold a result.
REQ-010 out_ready  input  1  SHALL mean the consumer takes the result this cycle.
REQ-011 out_data  output  2*XW  SHALL carry the approximate product.
REQ-012 out_id  output  ID_W  SHALL carry the index of the requester that issued the pair.
REQ-013 busy  output  1  SHALL be high whenever either pipeline stage holds valid data.

Function
REQ-014 The block SHALL contain exactly one instance of the team's approximate multiplier MUL_APP, shared by all requesters.
REQ-015 Stage S1 (operand register: a, b, id, v1) and stage S2 (product register: out_data, out_id, out_valid) SHALL form a 2-stage pipeline; MUL_APP sits combinationally between S1 and S2.
REQ-016 S2 SHALL load when out_valid is 0 or out_ready is 1 (adv2); it loads the MUL_APP output and S1 id, with out_valid <= v1.
REQ-017 S1 SHALL load when v1 is 0 or adv2 is 1 (adv1); v1 <= 1 if any request is granted, else 0.
REQ-018 Grant SHALL be round-robin: search req_valid starting at index ptr, wrapping from NREQ-1 to 0; the first set bit wins.
REQ-019 req_ready[g] SHALL be grant[g] AND adv1 AND NOT rst, combinationally; a transfer occurs when req_valid[g] and req_ready[g] are both 1.
REQ-020 On each transfer, ptr SHALL become (g+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-021 Latency SHALL be 2 cycles: a pair accepted at edge N appears with out_valid=1 after edge N+1, absent stall.
REQ-022 Throughput SHALL be one result per cycle while out_ready stays 1.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_id SHALL hold stable, S1 SHALL hold, and req_ready SHALL be 0 if S1 is full.
REQ-024 With one stalled result in S2 and S1 empty, exactly one further pair SHALL be accepted (2 in flight max); no result is dropped or duplicated.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 The block SHALL never lower out_valid without out_ready=1 (valid/ready stability rule).
REQ-027 Requesters SHALL hold req_a/req_b stable while req_valid=1 and not accepted; the block samples them only on the transfer cycle.
REQ-028 Zero operands SHALL pass through unchanged; out_data = 0 when either operand is 0.
REQ-029 Operands both below 2^6 SHALL produce the exact product (MUL_APP truncation inactive).

Reset
REQ-030 While rst=1 at a clock edge: v1=0, out_valid=0, out_data=0, out_id=0, ptr=0, S1 a/b/id=0; req_ready=0 combinationally; busy=0 after the edge.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight results without emitting them; the first grant after reset SHALL go to the lowest-index valid requester.

Verification
REQ-032 Single: req 2 presents a=3, b=5, out_ready=1 -> one transfer; 2 cycles later out_valid=1, out_data=15, out_id=2; then busy=0.
REQ-033 Round-robin: all 4 requesters valid continuously, a=i+1, b=2 -> grants 0,1,2,3,0,... one per cycle; out_data sequence 2,4,6,8,2...
REQ-034 Backpressure: out_ready=0 for 5 cycles with requester 0 streaming -> exactly 2 pairs accepted, out_data frozen, then results released in order with none lost.
REQ-035 Zero: a=0, b=0xFFFF -> out_data=0; a=0x003F, b=0x003F -> out_data=3969.
REQ-036 Reset mid-flight: rst for 1 cycle with both stages full -> out_valid=0 next cycle, no stale result emitted, ptr=0.
REQ-037 Fairness: requester 1 held valid for 100 cycles against 3 others always valid -> it is granted at least once every NREQ transfers.

Source files
------------

// File: rtl/mul_app_arbiter.sv
// Round-robin arbiter sharing one approximate multiplier between NREQ requesters
// through a two-stage (operand register, product register) valid/ready pipeline.

module mul_app #(
    parameter int XW = 16
) (
    input  logic [XW-1:0]   a,
    input  logic [XW-1:0]   b,
    output logic [2*XW-1:0] p
);
    // Each operand keeps only its six most significant bits (from its leading one);
    // operands below 64 pass through untouched, so small products stay exact.
    function automatic logic [XW-1:0] trunc6(input logic [XW-1:0] x);
        int msb;
        logic [XW-1:0] mask;
        msb = 0;
        for (int i = 0; i < XW; i++) begin
            if (x[i]) msb = i;
        end
        mask = {XW{1'b1}};
        if (msb > 5) mask = {XW{1'b1}} << (msb - 5);
        return x & mask;
    endfunction

    logic [2*XW-1:0] a_ext;
    logic [2*XW-1:0] b_ext;

    assign a_ext = {{XW{1'b0}}, trunc6(a)};
    assign b_ext = {{XW{1'b0}}, trunc6(b)};
    assign p     = a_ext * b_ext;
endmodule

module mul_app_arbiter #(
    parameter int NREQ = 4,
    parameter int XW   = 16,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XW-1:0]   req_a,
    input  logic [NREQ*XW-1:0]   req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*XW-1:0]      out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 busy
);
    logic [XW-1:0]   req_a_arr [NREQ];
    logic [XW-1:0]   req_b_arr [NREQ];

    logic [ID_W-1:0] ptr_reg;
    logic [XW-1:0]   a_reg;
    logic [XW-1:0]   b_reg;
    logic [ID_W-1:0] id_reg;
    logic            v1_reg;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] gidx;
    logic            any_grant;
    logic            adv1;
    logic            adv2;
    logic            transfer;
    logic [2*XW-1:0] product;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_a_arr[gi] = req_a[gi*XW +: XW];
            assign req_b_arr[gi] = req_b[gi*XW +: XW];
        end
    endgenerate

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int idx;
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_reg) + k) % NREQ;
            if (!any_grant && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = ID_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    assign adv2      = !out_valid || out_ready;
    assign adv1      = !v1_reg || adv2;
    assign transfer  = any_grant && adv1 && !rst;
    assign req_ready = grant & {NREQ{adv1 && !rst}};
    assign busy      = v1_reg || out_valid;

    mul_app #(.XW(XW)) u_mul_app (
        .a (a_reg),
        .b (b_reg),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            id_reg    <= '0;
            v1_reg    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            if (adv2) begin
                out_valid <= v1_reg;
                out_data  <= product;
                out_id    <= id_reg;
            end
            if (adv1) begin
                v1_reg <= any_grant;
                if (any_grant) begin
                    a_reg  <= req_a_arr[gidx];
                    b_reg  <= req_b_arr[gidx];
                    id_reg <= gidx;
                end
            end
            if (transfer) begin
                ptr_reg <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_app_arbiter.sv
// Randomized and directed bench for mul_app_arbiter against a transaction-level
// model: round-robin search, a two-deep in-flight queue and a truncating product.

module tb_mul_app_arbiter;
    localparam int NREQ = 4;
    localparam int XW   = 16;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*XW-1:0]  req_a;
    logic [NREQ*XW-1:0]  req_b;
    logic                out_valid;
    logic                out_ready;
    logic [2*XW-1:0]     out_data;
    logic [ID_W-1:0]     out_id;
    logic                busy;

    always #5 clk = ~clk;

    mul_app_arbiter #(.NREQ(NREQ), .XW(XW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    typedef struct {
        int              id;
        longint unsigned prod;
        int              acc;
    } item_t;

    int              errors = 0;
    int              checks = 0;
    item_t           sb[$];
    int              grant_log[$];
    longint unsigned pop_log[$];
    int              pop_id_log[$];
    int              m_ptr;
    int              cyc;
    logic [NREQ-1:0] vv;
    logic [XW-1:0]   va [NREQ];
    logic [XW-1:0]   vb [NREQ];
    logic            ordy;
    logic [NREQ-1:0] acc_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Keep the six leading significant bits of a value.
    function automatic longint unsigned keep6(input longint unsigned x);
        int p;
        p = 0;
        while ((x >> p) >= 64) p++;
        return (x >> p) << p;
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (vv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: drive, check at pre-edge, advance the model after the edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_ov;
        logic            pop;
        logic [2*XW-1:0] seen_data;
        int              seen_id;
        req_valid = vv;
        out_ready = ordy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*XW +: XW] = va[i];
            req_b[i*XW +: XW] = vb[i];
        end
        #1;
        g       = exp_grant();
        exp_rdy = '0;
        if (g >= 0 && !rst && (sb.size() < 2 || ordy)) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        exp_ov = (sb.size() > 0) && (sb[0].acc <= cyc - 1);
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("busy", 64'(busy), 64'(sb.size() > 0));
        if (exp_ov) begin
            chk("out_data", 64'(out_data), sb[0].prod);
            chk("out_id", 64'(out_id), 64'(sb[0].id));
        end
        pop       = exp_ov && ordy;
        seen_data = out_data;
        seen_id   = int'(out_id);
        @(posedge clk);
        cyc++;
        acc_last = '0;
        if (rst) begin
            sb.delete();
            m_ptr = 0;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                pop_log.push_back(longint'(seen_data));
                pop_id_log.push_back(seen_id);
            end
            if (exp_rdy != '0) begin
                sb.push_back('{g, keep6(64'(va[g])) * keep6(64'(vb[g])), cyc});
                m_ptr = (g + 1) % NREQ;
                grant_log.push_back(g);
                acc_last[g] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        vv   = '0;
        ordy = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int max_gap;
        int gap;
        int ones;
        logic [2*XW-1:0] frozen;

        rst = 1'b1; vv = '0; ordy = 1'b0; m_ptr = 0; cyc = 0; acc_last = '0;
        for (int i = 0; i < NREQ; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        @(negedge clk);

        // Reset state
        do_reset(2);
        #1;
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);

        // Single transfer from requester 2
        ordy = 1'b1;
        vv = 4'b0100; va[2] = 16'd3; vb[2] = 16'd5;
        base = pop_log.size();
        step();
        idle(3);
        chk("single_count", 64'(pop_log.size() - base), 64'd1);
        if (pop_log.size() > base) begin
            chk("single_data", 64'(pop_log[base]), 64'd15);
            chk("single_id", 64'(pop_id_log[base]), 64'd2);
        end
        chk("single_busy", 64'(busy), 64'd0);

        // Round-robin with every requester valid
        do_reset(1);
        grant_log.delete();
        base = pop_log.size();
        for (int i = 0; i < NREQ; i++) begin
            va[i] = XW'(i + 1);
            vb[i] = 16'd2;
        end
        vv = '1; ordy = 1'b1;
        for (int i = 0; i < 8; i++) step();
        idle(3);
        for (int k = 0; k < 8; k++) chk("rr_grant", 64'(grant_log[k]), 64'(k % NREQ));
        for (int k = 0; k < 8; k++) chk("rr_data", 64'(pop_log[base + k]), 64'(2 * (k % NREQ + 1)));

        // Backpressure: requester 0 streams while the consumer stalls
        base = grant_log.size();
        vv = 4'b0001; ordy = 1'b0; va[0] = 16'd10; vb[0] = 16'd7;
        frozen = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_last[0]) va[0] = va[0] + 1'b1;
            #1;
            if (i == 2) frozen = out_data;
            if (i > 2) chk("bp_frozen", 64'(out_data), 64'(frozen));
        end
        chk("bp_accepted", 64'(grant_log.size() - base), 64'd2);
        base = pop_log.size();
        idle(4);
        chk("bp_released", 64'(pop_log.size() - base), 64'd2);
        if (pop_log.size() >= base + 2) begin
            chk("bp_first", 64'(pop_log[base]), 64'd70);
            chk("bp_second", 64'(pop_log[base + 1]), 64'd77);
        end

        // Zero and largest exact operands
        base = pop_log.size();
        vv = 4'b0001; va[0] = 16'h0000; vb[0] = 16'hFFFF;
        step();
        va[0] = 16'h003F; vb[0] = 16'h003F;
        step();
        idle(3);
        chk("zero_count", 64'(pop_log.size() - base), 64'd2);
        if (pop_log.size() >= base + 2) begin
            chk("zero_prod", 64'(pop_log[base]), 64'd0);
            chk("exact_63", 64'(pop_log[base + 1]), 64'd3969);
        end

        // Reset with both stages full
        vv = '1; ordy = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("full_busy", 64'(busy), 64'd1);
        base = pop_log.size();
        do_reset(1);
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        vv = 4'b1010; ordy = 1'b1;
        step();
        chk("post_rst_grant", 64'(grant_log[grant_log.size() - 1]), 64'd1);
        idle(3);
        chk("post_rst_pops", 64'(pop_log.size() - base), 64'd1);

        // Fairness under random backpressure
        grant_log.delete();
        vv = '1;
        for (int i = 0; i < 100; i++) begin
            ordy = 1'($urandom_range(0, 1));
            step();
        end
        idle(3);
        max_gap = 0; gap = 0; ones = 0;
        foreach (grant_log[k]) begin
            gap++;
            if (grant_log[k] == 1) begin
                ones++;
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end
        end
        if (gap > max_gap) max_gap = gap;
        chk("fair_gap", 64'(max_gap <= NREQ), 64'd1);
        chk("fair_some", 64'(ones > 10), 64'd1);

        // Randomized traffic, holding operands until accepted
        vv = '0;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(vv[i] && !acc_last[i])) begin
                    vv[i] = ($urandom_range(0, 2) != 0);
                    va[i] = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 63)) : XW'($urandom);
                    vb[i] = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 63)) : XW'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(4);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
